uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter between the TAP command channel (read-address notifications)
//  and the TAP serialized data stream. Sits between the DMI UART TAP and the UART TX.
//  Framing: a command goes out as ESC_CHAR + cmd byte. A data byte equal to ESC_CHAR goes out as
//  ESC_CHAR + ESC_CHAR. The host uses this framing to split commands from data.
//  Buffers one-cycle command pulses in a small FIFO, because the command source has no back-pressure.
// PARAMETERS
//  ESC_CHAR   8'h1B  escape/prefix byte
//  CMD_DEPTH  2      command FIFO entries (power of 2, >=2)
// PORTS
//  CLK_I         in   1  clock, all logic on rising edge
//  RST_NI        in   1  reset, synchronous, active-low
//  CMD_VALID_I   in   1  one-cycle command push pulse (no handshake)
//  CMD_I         in   8  command byte, sampled with CMD_VALID_I
//  CMD_OVF_O     out  1  sticky: a push was dropped on a full FIFO
//  DATA_VALID_I  in   1  data byte offered
//  DATA_I        in   8  data byte
//  DATA_READY_O  out  1  data byte accepted when VALID&&READY
//  TX_READY_I    in   1  UART TX can take a byte
//  TX_WRITE_O    out  1  one-cycle byte strobe to UART TX
//  TX_DATA_O     out  8  byte to transmit, valid with TX_WRITE_O
//  BUSY_O        out  1  state!=IDLE || FIFO non-empty || data holding register full
// BEHAVIOUR
//  Reset values:
//   - all outputs 0; FIFO empty; data holding register empty; state IDLE.
//   - A reset mid-sequence abandons any half-sent escape pair.
//  Outputs: TX_WRITE_O, TX_DATA_O, DATA_READY_O and CMD_OVF_O are registered.
//  Issue rule:
//   - A byte is issued only in a cycle where TX_READY_I=1 and TX_WRITE_O was 0 in the previous cycle.
//   - Peak rate is therefore 1 byte per 2 clocks.
//  Command FIFO:
//   - Push on CMD_VALID_I, pop when the cmd byte is issued.
//   - Push while full and no pop in the same cycle: byte dropped, CMD_OVF_O<=1 until reset.
//   - Push while full with a pop in the same cycle: push accepted.
//   - Pointers are log2(CMD_DEPTH)+1 bits and wrap modulo 2*CMD_DEPTH.
//  Data holding register (1 entry):
//   - DATA_READY_O=1 only while the holding register is empty.
//   - A handshake loads the byte; the register is cleared when the data byte is issued.
//  FSM states: IDLE, CMD_ESC, CMD_BYTE, DAT_ESC, DAT_BYTE.
//   - IDLE: if an issue is allowed, take the next sequence by arbitration.
//   - Command sequence: emit ESC_CHAR -> CMD_BYTE.
//   - Data byte == ESC_CHAR: emit ESC_CHAR -> DAT_BYTE.
//   - Other data byte: emit it and stay in IDLE.
//   - CMD_ESC is not used as a wait state; ESC is emitted from IDLE.
//   - CMD_BYTE: on the next allowed issue, emit the FIFO head, pop, -> IDLE.
//   - DAT_ESC/DAT_BYTE: on the next allowed issue, emit the held byte, clear the register, -> IDLE.
//  Atomicity: an escape pair is never split. New commands wait until the state returns to IDLE.
//  Latency: command pushed with the arbiter idle and TX_READY_I=1
//   - ESC on TX_WRITE_O 2 cycles after the push;
//   - cmd byte 2 cycles after that (if TX_READY_I stays 1).
//  TX_READY_I dropping between the two bytes of a pair: hold state and wait; no timeout.
// CONFIGURATION
//  TX_ARB_FAIR_EN defined:
//   - After each command sequence, if the data holding register is full, one data sequence is
//     served before the next command.
//  TX_ARB_FAIR_EN undefined:
//   - Strict command priority. Data is served only when the FIFO is empty.
// TESTING
//  1. Reset, then push CMD 8'h05 with TX_READY_I=1
//     -> TX bytes 1B,05; CMD_OVF_O=0; BUSY_O=0 afterwards.
//  2. Stream data 8'hA0,8'h1B,8'h3C
//     -> TX bytes A0,1B,1B,3C; DATA_READY_O low while the holding register is full.
//  3. Hold TX_READY_I=0 and push 3 commands 01,02,03 (CMD_DEPTH=2)
//     -> CMD_OVF_O=1; release -> TX 1B,01,1B,02 only.
//  4. Data 8'h1B held and CMD 8'h07 pushed in the same cycle, TX ready
//     -> without FAIR: 1B,07,1B,1B.
//     -> with TX_ARB_FAIR_EN, after a prior cmd: 1B,1B,1B,07.
//  5. Drop TX_READY_I after the ESC of a command, raise it 5 cycles later
//     -> next byte is the cmd byte; no data interleaved.
//  6. Assert RST_NI=0 for 1 cycle between ESC and the cmd byte
//     -> all outputs 0 and FIFO empty the next cycle; no cmd byte emitted.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Groups the command, data and UART-TX signals of uart_tx_arbiter.
// Signal suffixes (_i/_o) are given from the arbiter's point of view.
//   cmd_valid_i / cmd_i      : one-cycle command push pulse and byte
//   cmd_ovf_o                : sticky command-FIFO overflow flag
//   data_valid_i / data_i    : data byte offered
//   data_ready_o             : data byte accepted when valid && ready
//   tx_ready_i               : UART TX can take a byte
//   tx_write_o / tx_data_o   : one-cycle byte strobe and byte to UART TX
//   busy_o                   : arbiter has work in flight
// Modports: master = TAP/UART side driving the arbiter, slave = the arbiter.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if;
    logic       cmd_valid_i;
    logic [7:0] cmd_i;
    logic       cmd_ovf_o;
    logic       data_valid_i;
    logic [7:0] data_i;
    logic       data_ready_o;
    logic       tx_ready_i;
    logic       tx_write_o;
    logic [7:0] tx_data_o;
    logic       busy_o;

    modport master (
        output cmd_valid_i, cmd_i, data_valid_i, data_i, tx_ready_i,
        input  cmd_ovf_o, data_ready_o, tx_write_o, tx_data_o, busy_o
    );

    modport slave (
        input  cmd_valid_i, cmd_i, data_valid_i, data_i, tx_ready_i,
        output cmd_ovf_o, data_ready_o, tx_write_o, tx_data_o, busy_o
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between the TAP command channel and the TAP
// data stream. A command is sent as ESC_CHAR + cmd; a data byte equal to
// ESC_CHAR is sent as ESC_CHAR + ESC_CHAR; other data bytes go out alone.
// Command pulses have no back-pressure and are buffered in a small FIFO.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : synchronous active-low reset
//   bus     : uart_tx_arbiter_if.slave (see interface file for signals)
// Optional feature macro: TX_ARB_FAIR_EN
//   defined   -> after each command sequence a waiting data byte is served
//                before the next command
//   undefined -> strict command priority, data only when the FIFO is empty
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter logic [7:0]  ESC_CHAR  = 8'h1B,
    parameter int unsigned CMD_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    uart_tx_arbiter_if.slave  bus
);
    localparam int unsigned AW = $clog2(CMD_DEPTH);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CMD_ESC  = 3'd1;
    localparam logic [2:0] ST_CMD_BYTE = 3'd2;
    localparam logic [2:0] ST_DAT_ESC  = 3'd3;
    localparam logic [2:0] ST_DAT_BYTE = 3'd4;

    logic [7:0]  fifo_q [CMD_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        ovf_q, ovf_d;
    logic        hold_full_q, hold_full_d;
    logic [7:0]  hold_data_q, hold_data_d;
    logic        data_ready_q, data_ready_d;
    logic [2:0]  state_q, state_d;
    logic        tx_write_q, tx_write_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        busy_q, busy_d;

    logic        fifo_empty_s, fifo_full_s, issue_ok_s, take_data_s;
    logic        pop_s, push_ok_s, hold_load_s, hold_clr_s;

    // FIFO status and issue permission (one byte per two clocks at most)
    always_comb begin
        fifo_empty_s = (wr_ptr_q == rd_ptr_q);
        fifo_full_s  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                       (wr_ptr_q[AW] != rd_ptr_q[AW]);
        issue_ok_s   = bus.tx_ready_i && !tx_write_q;
    end

`ifdef TX_ARB_FAIR_EN
    logic data_turn_q, data_turn_d;

    // Arbitration with a data turn granted after every completed command
    always_comb begin
        take_data_s = hold_full_q && (fifo_empty_s || data_turn_q);
        if (pop_s) begin
            data_turn_d = 1'b1;
        end else if ((state_q == ST_IDLE) && issue_ok_s && (hold_full_q || !fifo_empty_s)) begin
            data_turn_d = 1'b0;
        end else begin
            data_turn_d = data_turn_q;
        end
    end

    // Data-turn flag register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_turn_q <= 1'b0;
        end else begin
            data_turn_q <= data_turn_d;
        end
    end
`else
    // Strict command priority: data only when no command is queued
    always_comb begin
        take_data_s = hold_full_q && fifo_empty_s;
    end
`endif

    // Sequencing FSM: escape pairs are emitted atomically
    always_comb begin
        state_d    = state_q;
        tx_write_d = 1'b0;
        tx_data_d  = tx_data_q;
        pop_s      = 1'b0;
        hold_clr_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!issue_ok_s) begin
                    state_d = ST_IDLE;
                end else if (take_data_s) begin
                    tx_write_d = 1'b1;
                    tx_data_d  = hold_data_q;
                    if (hold_data_q == ESC_CHAR) begin
                        state_d = ST_DAT_BYTE;
                    end else begin
                        hold_clr_s = 1'b1;
                    end
                end else if (!fifo_empty_s) begin
                    tx_write_d = 1'b1;
                    tx_data_d  = ESC_CHAR;
                    state_d    = ST_CMD_BYTE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD_BYTE: begin
                if (issue_ok_s) begin
                    tx_write_d = 1'b1;
                    tx_data_d  = fifo_q[rd_ptr_q[AW-1:0]];
                    pop_s      = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_CMD_BYTE;
                end
            end
            ST_DAT_ESC, ST_DAT_BYTE: begin
                if (issue_ok_s) begin
                    tx_write_d = 1'b1;
                    tx_data_d  = hold_data_q;
                    hold_clr_s = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_CMD_ESC: begin
                // never entered: the command escape is emitted from IDLE
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Command FIFO pointers, overflow flag, data holding register, busy
    always_comb begin
        // a push into a full FIFO is still taken when the head leaves this cycle
        push_ok_s   = bus.cmd_valid_i && (!fifo_full_s || pop_s);
        ovf_d       = ovf_q || (bus.cmd_valid_i && fifo_full_s && !pop_s);
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        hold_load_s = bus.data_valid_i && data_ready_q;
        if (hold_load_s) begin
            hold_full_d = 1'b1;
            hold_data_d = bus.data_i;
        end else if (hold_clr_s) begin
            hold_full_d = 1'b0;
            hold_data_d = hold_data_q;
        end else begin
            hold_full_d = hold_full_q;
            hold_data_d = hold_data_q;
        end
        data_ready_d = !hold_full_d;
        busy_d       = (state_d != ST_IDLE) || (wr_ptr_d != rd_ptr_d) || hold_full_d;
    end

    // Command FIFO storage (contents need no reset; pointers define validity)
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= bus.cmd_i;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ovf_q        <= 1'b0;
            hold_full_q  <= 1'b0;
            hold_data_q  <= 8'h00;
            data_ready_q <= 1'b0;
            state_q      <= ST_IDLE;
            tx_write_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            busy_q       <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ovf_q        <= ovf_d;
            hold_full_q  <= hold_full_d;
            hold_data_q  <= hold_data_d;
            data_ready_q <= data_ready_d;
            state_q      <= state_d;
            tx_write_q   <= tx_write_d;
            tx_data_q    <= tx_data_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.cmd_ovf_o    = ovf_q;
    assign bus.data_ready_o = data_ready_q;
    assign bus.tx_write_o   = tx_write_q;
    assign bus.tx_data_o    = tx_data_q;
    assign bus.busy_o       = busy_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed scoreboard bench for uart_tx_arbiter. Expected TX bytes are queued
// when stimulus is issued; a monitor pops and compares on every TX strobe.
// Honours TX_ARB_FAIR_EN for the arbitration-order vector.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(.ESC_CHAR(8'h1B), .CMD_DEPTH(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [7:0] b);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_i       = b;
        tick();
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic send_data(input string name, input logic [7:0] b);
        int k = 0;
        bus.data_valid_i = 1'b1;
        bus.data_i       = b;
        while (!bus.data_ready_o && k < 100) begin
            tick();
            k++;
        end
        check({name, "_ready"}, {7'd0, bus.data_ready_o}, 8'd1);
        tick();
        bus.data_valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || bus.busy_o) && k < 200) begin
            tick();
            k++;
        end
        check({name, "_drained"}, 8'(exp_q.size()), 8'd0);
        check({name, "_busy"}, {7'd0, bus.busy_o}, 8'd0);
    endtask

    // global time guard
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n            = 1'b0;
        bus.cmd_valid_i  = 1'b0;
        bus.cmd_i        = 8'h00;
        bus.data_valid_i = 1'b0;
        bus.data_i       = 8'h00;
        bus.tx_ready_i   = 1'b1;

        fork
            begin : monitor
                logic [7:0] e;
                forever begin
                    @(negedge clk);
                    if (bus.tx_write_o === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL tx_unexpected: got %02h expected no byte", bus.tx_data_o);
                        end else begin
                            e = exp_q.pop_front();
                            check("tx_byte", bus.tx_data_o, e);
                        end
                    end
                end
            end
        join_none

        // reset state
        tick();
        tick();
        check("rst_tx_write", {7'd0, bus.tx_write_o}, 8'd0);
        check("rst_tx_data", bus.tx_data_o, 8'h00);
        check("rst_ovf", {7'd0, bus.cmd_ovf_o}, 8'd0);
        check("rst_data_ready", {7'd0, bus.data_ready_o}, 8'd0);
        check("rst_busy", {7'd0, bus.busy_o}, 8'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_data_ready", {7'd0, bus.data_ready_o}, 8'd1);

        // 1: single command with latency checks
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h05);
        push_cmd(8'h05);
        tick();
        check("t1_esc_lat", {7'd0, bus.tx_write_o}, 8'd1);
        tick();
        check("t1_gap", {7'd0, bus.tx_write_o}, 8'd0);
        tick();
        check("t1_cmd_lat", {7'd0, bus.tx_write_o}, 8'd1);
        check("t1_cmd_byte", bus.tx_data_o, 8'h05);
        drain("t1");
        check("t1_ovf", {7'd0, bus.cmd_ovf_o}, 8'd0);

        // 2: data stream with escaped byte
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h3C);
        send_data("t2_a0", 8'hA0);
        check("t2_ready_low_full", {7'd0, bus.data_ready_o}, 8'd0);
        send_data("t2_1b", 8'h1B);
        send_data("t2_3c", 8'h3C);
        drain("t2");

        // 3: overflow while TX stalled
        bus.tx_ready_i = 1'b0;
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h02);
        push_cmd(8'h01);
        push_cmd(8'h02);
        push_cmd(8'h03);
        check("t3_ovf_set", {7'd0, bus.cmd_ovf_o}, 8'd1);
        check("t3_busy", {7'd0, bus.busy_o}, 8'd1);
        bus.tx_ready_i = 1'b1;
        drain("t3");
        check("t3_ovf_sticky", {7'd0, bus.cmd_ovf_o}, 8'd1);
        rst_n = 1'b0;
        tick();
        check("t3_ovf_cleared", {7'd0, bus.cmd_ovf_o}, 8'd0);
        rst_n = 1'b1;
        tick();

        // prior command (grants the data turn in the fair build)
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h11);
        push_cmd(8'h11);
        drain("t4_prior");

        // 4: data ESC held and command pushed in the same cycle
        bus.tx_ready_i = 1'b0;
`ifdef TX_ARB_FAIR_EN
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h07);
`else
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h1B);
`endif
        check("t4_ready", {7'd0, bus.data_ready_o}, 8'd1);
        bus.data_valid_i = 1'b1;
        bus.data_i       = 8'h1B;
        bus.cmd_valid_i  = 1'b1;
        bus.cmd_i        = 8'h07;
        tick();
        bus.data_valid_i = 1'b0;
        bus.cmd_valid_i  = 1'b0;
        bus.tx_ready_i   = 1'b1;
        drain("t4");

        // 5: TX stall between the two bytes of a command pair
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h44);
        push_cmd(8'h22);
        tick();
        check("t5_esc", {7'd0, bus.tx_write_o}, 8'd1);
        bus.tx_ready_i = 1'b0;
        send_data("t5_data", 8'h44);
        for (int i = 0; i < 4; i++) begin
            check("t5_stalled", {7'd0, bus.tx_write_o}, 8'd0);
            tick();
        end
        check("t5_busy", {7'd0, bus.busy_o}, 8'd1);
        bus.tx_ready_i = 1'b1;
        drain("t5");

        // 6: reset between ESC and command byte
        exp_q.push_back(8'h1B);
        push_cmd(8'h33);
        tick();
        check("t6_esc", bus.tx_data_o, 8'h1B);
        rst_n = 1'b0;
        tick();
        check("t6_tx_write", {7'd0, bus.tx_write_o}, 8'd0);
        check("t6_tx_data", bus.tx_data_o, 8'h00);
        check("t6_data_ready", {7'd0, bus.data_ready_o}, 8'd0);
        check("t6_busy", {7'd0, bus.busy_o}, 8'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        check("t6_busy_after", {7'd0, bus.busy_o}, 8'd0);
        check("final_queue", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
